// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// MMIO register offsets and the byte-lane merge used by every writable word.
package data_sram_resp_pkg;

   localparam logic [15:0] MMIO_LED_OFF     = 16'h0000;
   localparam logic [15:0] MMIO_TIMER_OFF   = 16'h0004;
   localparam logic [15:0] MMIO_SCRATCH_OFF = 16'h0008;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  we);
      logic [31:0] res;
      res = old_data;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[8*i +: 8] = new_data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_resp_mmio.sv
// MMIO register block: LED, SCRATCH and (with DATA_SRAM_RESP_TIMER_EN) a free-running TIMER.
// The read mux is combinational; the top registers it into rdata.
module data_sram_resp_mmio
   import data_sram_resp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [3:0]  we,
   input  logic [15:0] off,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [15:0] led
);

   logic [15:0] led_q;
   logic [31:0] scratch_q;
   logic [31:0] timer_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= '0;
         scratch_q <= '0;
      end else if (sel) begin
         if (off == MMIO_LED_OFF) begin
            if (we[0]) led_q[7:0]  <= wdata[7:0];
            if (we[1]) led_q[15:8] <= wdata[15:8];
         end
         if (off == MMIO_SCRATCH_OFF) scratch_q <= byte_merge(scratch_q, wdata, we);
      end
   end

`ifdef DATA_SRAM_RESP_TIMER_EN
   logic [31:0] timer_q;

   // A write wins over the increment; unwritten lanes keep the pre-increment value.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else if (sel && (off == MMIO_TIMER_OFF) && (we != 4'b0000)) begin
         timer_q <= byte_merge(timer_q, wdata, we);
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end

   assign timer_rd = timer_q;
`else
   assign timer_rd = '0;
`endif

   always_comb begin
      rdata = '0;
      case (off)
         MMIO_LED_OFF:     rdata = {16'h0000, led_q};
         MMIO_TIMER_OFF:   rdata = timer_rd;
         MMIO_SCRATCH_OFF: rdata = scratch_q;
         default:          rdata = '0;
      endcase
   end

   assign led = led_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-enabled word RAM plus MMIO window, one-cycle read-first rdata.
// Optional TIMER register enabled by DATA_SRAM_RESP_TIMER_EN.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W    = 14,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [15:0] led
);

   localparam int unsigned Depth = 1 << ADDR_W;

   logic [31:0]       mem [Depth];
   logic [ADDR_W-1:0] idx;
   logic              is_mmio;
   logic              ram_wr;
   logic [31:0]       mmio_rdata;
   logic [31:0]       rdata_q;

   assign idx     = addr[ADDR_W+1:2];
   assign is_mmio = (addr[31:16] == MMIO_BASE[31:16]);
   // A request coinciding with reset is dropped entirely.
   assign ram_wr  = en && !reset && !is_mmio;

   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   data_sram_resp_mmio u_mmio (
      .clk   (clk),
      .reset (reset),
      .sel   (en && is_mmio),
      .we    (we),
      .off   (addr[15:0]),
      .wdata (wdata),
      .rdata (mmio_rdata),
      .led   (led)
   );

   // Non-blocking read of mem gives the pre-write word on write cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (en) begin
         rdata_q <= is_mmio ? mmio_rdata : mem[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed table, mid-stream reset sequence and
// randomized traffic against a behavioural model of RAM, LED, SCRATCH and TIMER.
module tb_data_sram_resp;

`ifdef DATA_SRAM_RESP_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif
   localparam logic [31:0] T102 = TIMER_ON ? 32'h0000_0102 : 32'h0;
   localparam logic [31:0] T103 = TIMER_ON ? 32'h0000_0103 : 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  we = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [15:0] led;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [31:0] ram [int];
   logic [31:0] m_rdata = 32'h0;
   bit          m_known = 1'b0;
   logic [15:0] m_led = 16'h0;
   logic [31:0] m_timer = 32'h0;
   logic [31:0] m_scratch = 32'h0;

   data_sram_resp dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .led   (led)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] w);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   task automatic model_step(input bit r, input bit e, input logic [3:0] w,
                             input logic [31:0] a, input logic [31:0] d);
      logic [31:0] old_t;
      logic [31:0] t_next;
      logic [31:0] tmp;
      logic [15:0] off;
      int          k;
      old_t = m_timer;
      t_next = old_t + 32'd1;
      off = a[15:0];
      k = int'(a[15:2]);
      if (r) begin
         m_rdata = 0; m_known = 1; m_led = 0; m_timer = 0; m_scratch = 0;
         return;
      end
      if (e) begin
         if (a[31:16] == 16'hBFAF) begin
            m_known = 1;
            case (off)
               16'h0000: m_rdata = {16'h0, m_led};
               16'h0004: m_rdata = TIMER_ON ? old_t : 32'h0;
               16'h0008: m_rdata = m_scratch;
               default:  m_rdata = 32'h0;
            endcase
            if (off == 16'h0000) begin
               tmp = merge({16'h0, m_led}, d, w);
               m_led = tmp[15:0];
            end
            if (off == 16'h0008) m_scratch = merge(m_scratch, d, w);
            if (off == 16'h0004 && w != 4'h0 && TIMER_ON) t_next = merge(old_t, d, w);
         end else if (ram.exists(k)) begin
            m_rdata = ram[k];
            m_known = 1;
            ram[k] = merge(ram[k], d, w);
         end else begin
            m_known = 0;
            if (w == 4'hF) ram[k] = d;
         end
      end
      m_timer = t_next;
   endtask

   task automatic do_cycle(input bit r, input bit e, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d);
      reset = r; en = e; we = w; addr = a; wdata = d;
      @(posedge clk);
      model_step(r, e, w, a, d);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   typedef struct {
      bit          rst;
      bit          en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input bit c, input logic [31:0] er,
                      input logic [15:0] el);
      vec_t v;
      v = '{rst: 1'b0, en: e, we: w, addr: a, wdata: d, chk: c, exp_rdata: er, exp_led: el};
      tbl.push_back(v);
   endtask

   initial begin
      // Directed table: expectations are outputs after the edge ending that cycle
      add(1, 4'h0, 32'hBFAF_0004, 32'h0,          1, 32'h0,          16'h0);
      add(1, 4'hF, 32'h0000_1000, 32'h1234_5678,  0, 32'h0,          16'h0);
      add(1, 4'h0, 32'h0000_1000, 32'h0,          1, 32'h1234_5678,  16'h0);
      add(1, 4'h2, 32'h0000_1000, 32'h0000_AB00,  1, 32'h1234_5678,  16'h0);
      add(1, 4'h0, 32'h0000_1000, 32'h0,          1, 32'h1234_AB78,  16'h0);
      add(1, 4'h8, 32'h0000_1000, 32'hCD00_0000,  1, 32'h1234_AB78,  16'h0);
      add(1, 4'h0, 32'h0000_1000, 32'h0,          1, 32'hCD34_AB78,  16'h0);
      add(1, 4'hF, 32'h0000_2000, 32'h1111_1111,  0, 32'h0,          16'h0);
      add(1, 4'hF, 32'h0000_2000, 32'h2222_2222,  1, 32'h1111_1111,  16'h0);
      add(0, 4'h0, 32'h0000_2000, 32'h0,          1, 32'h1111_1111,  16'h0);
      add(0, 4'hF, 32'h0000_2000, 32'h9999_9999,  1, 32'h1111_1111,  16'h0);
      add(0, 4'h0, 32'h0000_2000, 32'h0,          1, 32'h1111_1111,  16'h0);
      add(1, 4'h0, 32'h0000_2000, 32'h0,          1, 32'h2222_2222,  16'h0);
      add(1, 4'hF, 32'hBFAF_0000, 32'hFFFF_A5A5,  1, 32'h0,          16'hA5A5);
      add(1, 4'h0, 32'hBFAF_0000, 32'h0,          1, 32'h0000_A5A5,  16'hA5A5);
      add(1, 4'hF, 32'hBFAF_0010, 32'h1234_5678,  1, 32'h0,          16'hA5A5);
      add(1, 4'h0, 32'hBFAF_0010, 32'h0,          1, 32'h0,          16'hA5A5);
      add(1, 4'hF, 32'hBFAF_0008, 32'hDEAD_BEEF,  1, 32'h0,          16'hA5A5);
      add(1, 4'h1, 32'hBFAF_0008, 32'h0000_0011,  1, 32'hDEAD_BEEF,  16'hA5A5);
      add(1, 4'h0, 32'hBFAF_0008, 32'h0,          1, 32'hDEAD_BE11,  16'hA5A5);
      add(1, 4'hF, 32'hBFAF_0004, 32'h0000_0100,  0, 32'h0,          16'hA5A5);
      add(0, 4'h0, 32'h0,         32'h0,          0, 32'h0,          16'hA5A5);
      add(0, 4'h0, 32'h0,         32'h0,          0, 32'h0,          16'hA5A5);
      add(1, 4'h0, 32'hBFAF_0004, 32'h0,          1, T102,           16'hA5A5);
      add(1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF,  1, T103,           16'hA5A5);
      add(0, 4'h0, 32'h0,         32'h0,          1, T103,           16'hA5A5);
      add(1, 4'h0, 32'hBFAF_0004, 32'h0,          1, 32'h0,          16'hA5A5);

      // Reset held for two cycles
      do_cycle(1, 0, 4'h0, 32'h0, 32'h0);
      do_cycle(1, 1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF);
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);

      foreach (tbl[i]) begin
         do_cycle(tbl[i].rst, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      end

      // Initialise the RAM words used by random traffic
      for (int k = 0; k < 16; k++) do_cycle(0, 1, 4'hF, 32'h4000 + 32'(k * 4), $urandom);

      for (int n = 0; n < 400; n++) begin
         logic [15:0] hi;
         logic [31:0] a;
         logic [3:0]  w;
         bit          r;
         bit          e;
         logic [15:0] offs [5];
         offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 9) < 3) begin
            a = {16'hBFAF, offs[$urandom_range(0, 4)]};
         end else begin
            hi = 16'($urandom);
            if (hi == 16'hBFAF) hi = 16'h0;
            a = {hi, 16'h4000 + 16'($urandom_range(0, 15) * 4)};
         end
         do_cycle(r, e, w, a, $urandom);
         if (m_known) check($sformatf("rnd%0d_rdata", n), rdata, m_rdata);
         check($sformatf("rnd%0d_led", n), {16'h0, led}, {16'h0, m_led});
      end

      // Reset mid-stream drops the concurrent write; earlier RAM writes survive
      do_cycle(0, 1, 4'hF, 32'h0000_3000, 32'hAAAA_5555);
      do_cycle(0, 1, 4'hF, 32'hBFAF_0000, 32'h0000_1234);
      do_cycle(0, 1, 4'hF, 32'hBFAF_0008, 32'h0000_0077);
      check("pre_rst_led", {16'h0, led}, 32'h0000_1234);
      do_cycle(1, 1, 4'hF, 32'h0000_3000, 32'hBBBB_BBBB);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_led", {16'h0, led}, 32'h0);
      do_cycle(0, 1, 4'h0, 32'hBFAF_0004, 32'h0);
      check("post_rst_timer", rdata, 32'h0);
      do_cycle(0, 1, 4'h0, 32'h0000_3000, 32'h0);
      check("post_rst_ram", rdata, 32'hAAAA_5555);
      do_cycle(0, 1, 4'h0, 32'hBFAF_0008, 32'h0);
      check("post_rst_scratch", rdata, 32'h0);
      do_cycle(0, 1, 4'h0, 32'hBFAF_0000, 32'h0);
      check("post_rst_led_rd", rdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU data SRAM interface. Accepts the core's `data_sram_en/we/addr/wdata` requests and returns `data_sram_rdata` with fixed one-cycle latency. Backed by a word-organised RAM with byte write enables, plus a small MMIO window holding an LED register, a scratch register and a free-running timer. It sits outside `mycpu_top` in the SoC shell, with ports wired one-to-one to the core's data SRAM ports.

## Interface

Parameters:
- `ADDR_W`, 14 — word-address bits of the RAM; depth is 2^ADDR_W words (64 KiB at default).
- `MMIO_BASE`, 32'hBFAF_0000 — base of the MMIO window; only bits [31:16] are compared.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  request valid this cycle.
- `we`  in  4  byte write enables; 4'b0000 with `en`=1 means read.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  write data; lane i is `wdata[8i+7:8i]`, gated by `we[i]`.
- `rdata`  out  32  read data, registered.
- `led`  out  16  LED register contents.

## Operation

- Region decode: `addr[31:16] == MMIO_BASE[31:16]` selects MMIO; anything else selects RAM.
- RAM index is `addr[ADDR_W+1:2]`. Upper address bits alias silently.
- RAM contents are not reset.
- RAM write: when `en`=1, each lane with `we[i]`=1 is written. Lanes with `we[i]`=0 keep their value.
- Every `en`=1 cycle, including write cycles, loads `rdata` with the addressed word's content from before this cycle's write (read-first).
- `en`=0: `rdata` holds its last value.
- MMIO offsets are taken from `addr[15:0]`:
  - 0x0000 LED: bits [15:0] are read/write, bits [31:16] read 0. Byte enables apply.
  - 0x0004 TIMER: 32-bit counter, read/write, byte enables apply.
  - 0x0008 SCRATCH: 32-bit read/write, byte enables apply.
  - Any other offset reads 0; writes are ignored.
- TIMER increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
- A TIMER write in cycle N takes priority over the increment: timer = merged write value after edge N. Masked lanes are merged from the pre-increment value.
- A TIMER read in cycle N returns the value held during cycle N (pre-increment).
- `led` is driven straight from the LED register and updates on the edge ending the write cycle.

## Timing

- Reset values: `rdata`=0, `led`=0, TIMER=0, SCRATCH=0.
- Read latency: request in cycle N gives `rdata` valid from edge N+1 through the next `en` cycle.
- Back-to-back requests run every cycle with no stalls and no backpressure.
- Write in cycle N then read of the same address in cycle N+1 returns the new data.
- Write and read in the same cycle (a single request) return the old data.
- `reset` asserted mid-stream:
  - The request in that cycle is dropped: no RAM or MMIO write takes effect.
  - `rdata`, `led`, TIMER and SCRATCH go to 0 on that edge.
  - RAM keeps any writes completed before reset.

## Configuration

- `DATA_SRAM_RESP_TIMER_EN` defined: TIMER is implemented as described.
- Not defined: no counter is synthesised. Offset 0x0004 reads 0 and ignores writes. All other behaviour is unchanged.

## Structure

- Shared package `data_sram_resp_pkg`:
  - MMIO offset constants `MMIO_LED_OFF`, `MMIO_TIMER_OFF`, `MMIO_SCRATCH_OFF`.
  - Function `byte_merge(old, new, we)` returning the lane-merged word.
- One sub-module `data_sram_resp_mmio` holds the LED, SCRATCH and TIMER registers and the MMIO read mux.
- The top level holds the RAM array, the region decode and the `rdata` register.

## Test plan

- Reset: assert `reset` 2 cycles -> `rdata`=0, `led`=0; read of 0xBFAF_0004 issued in the first cycle after reset returns 0.
- Full write/read: write 0x1234_5678, `we`=4'hF, to 0x0000_1000, then read 0x0000_1000 next cycle -> `rdata`=0x1234_5678 one cycle after the read.
- Byte lanes: then write `we`=4'b0010, `wdata`=0x0000_AB00, to 0x1000; read -> 0x1234_AB78. Then `we`=4'b1000, `wdata`=0xCD00_0000 -> 0xCD34_AB78.
- Read-first and hold: on a word holding 0x1111_1111, write 0x2222_2222 -> `rdata`=0x1111_1111 after that edge. Idle 3 cycles -> `rdata` stays 0x1111_1111. Read -> 0x2222_2222.
- LED: write 0xFFFF_A5A5, `we`=4'hF, to 0xBFAF_0000 -> `led`=16'hA5A5 next cycle; readback 0x0000_A5A5. Write to 0xBFAF_0010 is ignored; its read returns 0.
- TIMER (macro defined): write 0x0000_0100 in cycle N; read in cycle N+3 -> 0x0000_0102. Write 0xFFFF_FFFF, then read 2 cycles later -> 0x0000_0000 (wrap). Without the macro, the same reads return 0.
